// File: rtl/data_memory_if.sv
// Memory-stage bus between the datapath and the data memory: shared word
// address, store data, write enable and combinational load data.
interface data_memory_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] read_write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  MemWrite;
    logic [DATA_WIDTH-1:0] read_data;

    // Datapath side: drives address, data and write enable, receives load data.
    modport master (
        output read_write_addr,
        output write_data,
        output MemWrite,
        input  read_data
    );

    // Memory side: samples the request, returns load data.
    modport slave (
        input  read_write_addr,
        input  write_data,
        input  MemWrite,
        output read_data
    );
endinterface

// File: rtl/data_memory.sv
// Word-addressed data memory for the single-cycle datapath.
// Stores commit on the rising clock edge; loads are combinational.
// Storage is a register array so an asynchronous reset can clear every word.
// Addresses at or beyond DEPTH read as zero and never write, so high address
// bits never alias onto valid words.
module data_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic          clock,
    input  logic          reset,
    data_memory_if.slave  bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic                  in_range_s;
    logic [IDX_W-1:0]      idx_s;
    logic                  wr_en_s;

    // Decode the shared address: range check and word index.
    always_comb begin
        in_range_s = 1'b0;
        idx_s      = {IDX_W{1'b0}};
        if (bus.read_write_addr < DEPTH_A) begin
            in_range_s = 1'b1;
            idx_s      = bus.read_write_addr[IDX_W-1:0];
        end else begin
            in_range_s = 1'b0;
            idx_s      = {IDX_W{1'b0}};
        end
    end

    // Write enable only for a definite 1; X or Z falls to the else branch.
    always_comb begin
        wr_en_s = 1'b0;
        if ((bus.MemWrite == 1'b1) && in_range_s) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Combinational load path; out-of-range addresses return zero.
    always_comb begin
        bus.read_data = {DATA_WIDTH{1'b0}};
        if (in_range_s) begin
            bus.read_data = mem_r[idx_s];
        end else begin
            bus.read_data = {DATA_WIDTH{1'b0}};
        end
    end

    // Storage array: async clear on reset, otherwise commit enabled stores.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_r[idx_s] <= bus.write_data;
        end
    end
endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory.
module tb_data_memory;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 256;

    logic clock;
    logic reset;
    int   tests_run;
    int   tests_failed;

    data_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    data_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive a request at the falling edge so it is stable at the next rising edge.
    task automatic drive(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we);
        @(negedge clock);
        bus.read_write_addr = a;
        bus.write_data      = d;
        bus.MemWrite        = we;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        drive(a, d, 1'b1);
        @(posedge clock);
        #1;
        bus.MemWrite = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        bus.MemWrite        = 1'b0;
        bus.read_write_addr = a;
        #1;
        check_val(tag, bus.read_data, exp);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset               = 1'b1;
        bus.read_write_addr = '0;
        bus.write_data      = '0;
        bus.MemWrite        = 1'b0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check_val("rst_hold_a0", bus.read_data, 32'h0000_0000);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            read_check($sformatf("rst_a%0d", i), AW'(i), 32'h0000_0000);
        end

        // Back-to-back writes, each visible right after its own edge
        drive(32'd1, 32'd16, 1'b1);
        @(posedge clock); #1;
        check_val("wr1_after_edge", bus.read_data, 32'd16);
        drive(32'd3, 32'd27, 1'b1);
        @(posedge clock); #1;
        check_val("wr3_after_edge", bus.read_data, 32'd27);
        @(negedge clock);
        read_check("rd_a1", 32'd1, 32'd16);
        read_check("rd_a2", 32'd2, 32'd0);
        read_check("rd_a3", 32'd3, 32'd27);

        // Read-during-write: old value before edge, new value after
        write_word(32'd5, 32'd7);
        drive(32'd5, 32'd9, 1'b1);
        #1;
        check_val("rdw_before", bus.read_data, 32'd7);
        @(posedge clock); #1;
        check_val("rdw_after", bus.read_data, 32'd9);

        // Write enable low, then X on the enable: no change
        drive(32'd3, 32'hFFFF_FFFF, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        check_val("we_low_a3", bus.read_data, 32'd27);
        drive(32'd3, 32'hFFFF_FFFF, 1'bx);
        repeat (2) @(posedge clock);
        #1;
        bus.MemWrite = 1'b0;
        #1;
        check_val("we_x_a3", bus.read_data, 32'd27);

        // Out of range: dropped, no aliasing onto low words
        write_word(32'd0, 32'h0000_0011);
        write_word(32'd256, 32'h0000_DEAD);
        read_check("oor_a256", 32'd256, 32'h0000_0000);
        read_check("oor_alias_a0", 32'd0, 32'h0000_0011);
        write_word(32'h8000_0001, 32'h0000_BEEF);
        read_check("oor_alias_a1", 32'd1, 32'd16);

        // Asynchronous reset between edges, coincident write blocked
        @(negedge clock);
        bus.read_write_addr = 32'd1;
        #2;
        check_val("pre_rst_a1", bus.read_data, 32'd16);
        reset = 1'b1;
        #1;
        check_val("async_rst_a1", bus.read_data, 32'd0);
        bus.write_data = 32'd55;
        bus.MemWrite   = 1'b1;
        @(posedge clock); #1;
        check_val("rst_blocks_wr", bus.read_data, 32'd0);
        @(negedge clock);
        bus.MemWrite = 1'b0;
        reset        = 1'b0;
        read_check("post_rst_a3", 32'd3, 32'd0);
        read_check("post_rst_a5", 32'd5, 32'd0);
        write_word(32'd1, 32'd42);
        read_check("post_rst_wr_a1", 32'd1, 32'd42);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
